// File: rtl/router_pkt_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkt_sink: round-robin packet reader for a 3-channel router,   |
// | checks header address, parity and stalls.   Rev 1.0                  |
// +----------------------------------------------------------------------+
module router_pkt_sink #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_out_0,
    input  logic        vld_out_1,
    input  logic        vld_out_2,
    input  logic [7:0]  data_out_0,
    input  logic [7:0]  data_out_1,
    input  logic [7:0]  data_out_2,
    output logic        read_enb_0,
    output logic        read_enb_1,
    output logic        read_enb_2,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        pkt_done,
    output logic [1:0]  pkt_chan,
    output logic [5:0]  pkt_len,
    output logic        parity_err,
    output logic        addr_err,
    output logic        trunc_err,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
);
    localparam int c_STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_ONE  = c_STALL_W'(1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_HDR_REQ  = 3'd1;
    localparam logic [2:0] c_HDR_WAIT = 3'd2;
    localparam logic [2:0] c_BODY     = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    logic [2:0]           r_state, w_state_nxt;
    logic [1:0]           r_chan, r_rr_ptr;
    logic [5:0]           r_len;
    logic [6:0]           r_req_left, r_rcv_left;
    logic                 r_rd_pend, r_addr_bad;
    logic [7:0]           r_parity;
    logic [c_STALL_W-1:0] r_stall;

    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_pkt_done, r_parity_err, r_addr_err, r_trunc_err;
    logic [1:0]  r_pkt_chan;
    logic [5:0]  r_pkt_len;
    logic [15:0] r_pkt_count;
    logic [7:0]  r_err_count;

    logic [3:0]  w_vld;
    logic [7:0]  w_din;
    logic [1:0]  w_c1, w_c2, w_pick;
    logic        w_pick_ok, w_rd_en, w_stalling, w_abort;
    logic        w_last_byte, w_parity_bad, w_enter_done, w_good;

    assign w_vld = {1'b0, vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        w_din = data_out_0;
        case (r_chan)
            2'd1:    w_din = data_out_1;
            2'd2:    w_din = data_out_2;
            default: w_din = data_out_0;
        endcase
    end

    // Round-robin search order: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
    always_comb begin
        w_c1      = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
        w_c2      = (r_rr_ptr == 2'd0) ? 2'd2 : r_rr_ptr - 2'd1;
        w_pick_ok = 1'b1;
        w_pick    = r_rr_ptr;
        if (w_vld[r_rr_ptr])  w_pick = r_rr_ptr;
        else if (w_vld[w_c1]) w_pick = w_c1;
        else if (w_vld[w_c2]) w_pick = w_c2;
        else                  w_pick_ok = 1'b0;
    end

    assign w_last_byte  = (r_state == c_BODY) && r_rd_pend && (r_rcv_left == 7'd1);
    assign w_parity_bad = ((r_parity ^ w_din) != 8'h00);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_stalling  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pick_ok) w_state_nxt = c_HDR_REQ;
            end
            c_HDR_REQ: begin
                if (w_vld[r_chan]) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = c_HDR_WAIT;
                end else begin
                    w_stalling = 1'b1;
                    if (r_stall == c_STALL_LAST) begin
                        w_abort     = 1'b1;
                        w_state_nxt = c_DONE;
                    end
                end
            end
            c_HDR_WAIT: w_state_nxt = c_BODY;
            c_BODY: begin
                if (r_req_left != 7'd0) begin
                    if (w_vld[r_chan]) begin
                        w_rd_en = 1'b1;
                    end else begin
                        w_stalling = 1'b1;
                        if (r_stall == c_STALL_LAST) w_abort = 1'b1;
                    end
                end
                if (w_abort || w_last_byte) w_state_nxt = c_DONE;
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign w_enter_done = (w_state_nxt == c_DONE) && (r_state != c_DONE);
    assign w_good       = !w_abort && !w_parity_bad && !r_addr_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_chan       <= 2'd0;
            r_rr_ptr     <= 2'd0;
            r_len        <= 6'd0;
            r_req_left   <= 7'd0;
            r_rcv_left   <= 7'd0;
            r_rd_pend    <= 1'b0;
            r_addr_bad   <= 1'b0;
            r_parity     <= 8'h00;
            r_stall      <= '0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_chan   <= 2'd0;
            r_pkt_len    <= 6'd0;
            r_parity_err <= 1'b0;
            r_addr_err   <= 1'b0;
            r_trunc_err  <= 1'b0;
            r_pkt_count  <= 16'd0;
            r_err_count  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_pend  <= w_rd_en;
            r_rx_valid <= 1'b0;
            r_pkt_done <= 1'b0;
            r_stall    <= w_stalling ? r_stall + c_STALL_ONE : '0;

            case (r_state)
                c_IDLE: begin
                    if (w_pick_ok) begin
                        r_chan     <= w_pick;
                        r_len      <= 6'd0;
                        r_addr_bad <= 1'b0;
                    end
                end
                c_HDR_WAIT: begin
                    r_len      <= w_din[7:2];
                    r_req_left <= {1'b0, w_din[7:2]} + 7'd1;
                    r_rcv_left <= {1'b0, w_din[7:2]} + 7'd1;
                    r_parity   <= w_din;
                    r_addr_bad <= (w_din[1:0] != r_chan);
                end
                c_BODY: begin
                    if (w_rd_en) r_req_left <= r_req_left - 7'd1;
                    if (r_rd_pend) begin
                        r_parity   <= r_parity ^ w_din;
                        r_rcv_left <= r_rcv_left - 7'd1;
                        // The last byte of the packet is the parity byte, never forwarded
                        if (r_rcv_left > 7'd1) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= w_din;
                        end
                    end
                end
                c_DONE: r_rr_ptr <= (r_chan == 2'd2) ? 2'd0 : r_chan + 2'd1;
                default: ;
            endcase

            if (w_enter_done) begin
                r_pkt_done   <= 1'b1;
                r_pkt_chan   <= r_chan;
                r_pkt_len    <= r_len;
                r_parity_err <= !w_abort && w_parity_bad;
                r_addr_err   <= r_addr_bad;
                r_trunc_err  <= w_abort;
                if (w_good)                    r_pkt_count <= r_pkt_count + 16'd1;
                else if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign read_enb_0 = w_rd_en && (r_chan == 2'd0);
    assign read_enb_1 = w_rd_en && (r_chan == 2'd1);
    assign read_enb_2 = w_rd_en && (r_chan == 2'd2);
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign pkt_done   = r_pkt_done;
    assign pkt_chan   = r_pkt_chan;
    assign pkt_len    = r_pkt_len;
    assign parity_err = r_parity_err;
    assign addr_err   = r_addr_err;
    assign trunc_err  = r_trunc_err;
    assign pkt_count  = r_pkt_count;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/router_pkt_sink.md
ROUTER_PKT_SINK -- requirements
Module: router_pkt_sink

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, meaning the maximum number of consecutive stall cycles (vld_out low mid-packet) before a packet is aborted.
REQ-002 SHALL have these ports, one per line, clock and reset first:
 clk  input  1  single clock; all logic on rising edge
 rst  input  1  reset; synchronous, active-low
 vld_out_0/1/2  input  1 each  router channel FIFO not-empty
 data_out_0/1/2  input  8 each  router channel read data; valid one cycle after the read_enb sampled high
 read_enb_0/1/2  output  1 each  pop request to the router channel
 rx_data  output  8  captured payload byte
 rx_valid  output  1  rx_data qualifier, one-cycle pulse per payload byte
 pkt_done  output  1  one-cycle pulse at packet end (good or bad)
 pkt_chan  output  2  channel of the last completed packet
 pkt_len  output  6  header length field of the last packet
 parity_err  output  1  with pkt_done: computed parity != received parity byte
 addr_err  output  1  with pkt_done: header addr[1:0] != served channel
 trunc_err  output  1  with pkt_done: packet aborted by timeout
 pkt_count  output  16  good packets received, wraps
 err_count  output  8  bad packets, saturates at 255

Function
REQ-003 SHALL use packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then parity = XOR of header and all payload bytes.
REQ-004 SHALL have FSM states IDLE, HDR_REQ, HDR_WAIT, BODY, DONE.
REQ-005 IDLE: SHALL pick a channel whose vld_out is high using round-robin starting at rr_ptr; go to HDR_REQ next cycle; stay IDLE if none valid.
REQ-006 SHALL assert read_enb only on the selected channel and only in a cycle where that channel's vld_out is high; other read_enb lines SHALL remain 0.
REQ-007 HDR_REQ: SHALL assert read_enb one cycle when vld_out high, then HDR_WAIT.
REQ-008 HDR_WAIT: SHALL capture the header from data_out, load remaining = len+1 bytes to request, seed parity accumulator with header, go to BODY.
REQ-009 BODY: SHALL assert read_enb every cycle vld_out high and requests outstanding > 0 (back-to-back streaming, one byte per cycle).
REQ-010 BODY: each returned byte SHALL be XORed into parity; first len returned bytes SHALL pulse rx_valid with rx_data; the final returned byte SHALL be compared as parity and not output on rx_data.
REQ-011 len = 0: BODY SHALL request exactly one byte (parity), no rx_valid pulses.
REQ-012 DONE: one cycle; SHALL pulse pkt_done with pkt_chan, pkt_len, parity_err, addr_err, trunc_err valid in that cycle; rr_ptr SHALL advance to served channel + 1 (mod 3); return to IDLE.
REQ-013 pkt_count SHALL increment (wrap 0xFFFF→0) when all error flags are 0; otherwise err_count SHALL increment, holding at 255.
REQ-014 Stall counter SHALL count consecutive HDR_REQ/BODY cycles with read needed and vld_out low, clear on any read; at count = TIMEOUT SHALL go to DONE with trunc_err = 1, parity_err = 0, no further reads.
REQ-015 addr = 2'b11 or mismatch SHALL set addr_err but packet SHALL still be fully drained.
REQ-016 Error flags SHALL hold their values until the next pkt_done.

Reset
REQ-017 While rst = 0 at a clock edge: state IDLE, rr_ptr = 0, all read_enb = 0, rx_valid = 0, pkt_done = 0, rx_data = 0, pkt_chan = 0, pkt_len = 0, all error flags = 0, pkt_count = 0, err_count = 0, stall counter = 0.
REQ-018 Reset mid-packet SHALL abandon the packet with no pkt_done pulse; any read data returning the cycle after reset release SHALL be ignored.

Verification
REQ-019 Channel 0, header 0x38 (len 14, addr 0), 14 bytes, correct parity -> 14 rx_valid pulses in order, pkt_done with pkt_len=14, pkt_chan=0, no errors, pkt_count=1.
REQ-020 Channel 1, len 12 header 0x31, last byte parity XOR 0x01 -> pkt_done with parity_err=1, err_count=1, pkt_count unchanged.
REQ-021 Channels 0 and 2 valid simultaneously from reset -> channel 0 served first, then channel 2, read_enb never high on two channels at once.
REQ-022 Channel 2, len 16 header 0x42, vld_out dropped for TIMEOUT cycles after byte 5 -> pkt_done with trunc_err=1 exactly TIMEOUT stall cycles later.
REQ-023 Channel 0 with header 0x02 (len 0, addr 2) -> one parity read, no rx_valid, pkt_done with addr_err=1, pkt_len=0.
REQ-024 rst low mid-payload of a len 19 packet -> all outputs at reset values next cycle, no pkt_done, next packet after release received correctly.
